ram_fifo_ctrl: RTL

- Controller that sequences an external 16x8 synchronous dual-port RAM as a first-in/first-out queue.
- RAM port A is the write port; RAM port B is the read port.
- Generates addresses and write enables, tracks occupancy, and signals full/empty, almost-full, pop-data validity and sticky misuse errors.
- Sits between a producer and a consumer that exchange byte streams through the shared RAM.

---
 rtl/fifo_pkg.sv | 18 +
 rtl/fifo_ptr.sv | 24 ++
 rtl/ram_fifo_ctrl.sv | 102 ++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and types for the RAM-backed FIFO controller.
// Geometry defaults describe the 16x8 dual-port RAM the controller normally sequences.
package fifo_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 4;
  localparam int DEPTH      = 2 ** DEF_ADDR_W;
  localparam int CNT_W      = DEF_ADDR_W + 1;

  // Encoded as {push_ok, pop_ok} so the accept pair can be cast directly.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } op_e;

endpackage

// File: rtl/fifo_ptr.sv
// Wrapping FIFO pointer: low ADDR_W bits address the RAM, MSB is the wrap bit.
// Counts modulo 2**(ADDR_W+1) on inc; synchronous active-high reset to zero.
module fifo_ptr #(
  parameter int ADDR_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inc,
  output logic [ADDR_W:0] ptr
);

  logic [ADDR_W:0] ptr_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_reg <= '0;
    end else if (inc) begin
      ptr_reg <= ptr_reg + 1'b1;
    end
  end

  assign ptr = ptr_reg;

endmodule

// File: rtl/ram_fifo_ctrl.sv
// Sequences an external synchronous dual-port RAM as a FIFO: port A writes, port B reads.
// Tracks occupancy and flags; pop_data is the RAM's registered port-B output passed through.
module ram_fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int AF_LEVEL = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  output logic              full,
  output logic              almost_full,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic              pop_valid,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow,
  output logic              ram_we_a,
  output logic [ADDR_W-1:0] ram_addr_a,
  output logic [DATA_W-1:0] ram_din_a,
  output logic              ram_we_b,
  output logic [ADDR_W-1:0] ram_addr_b,
  output logic [DATA_W-1:0] ram_din_b,
  input  logic [DATA_W-1:0] ram_dout_b
);

  localparam int              PTR_W  = ADDR_W + 1;
  localparam logic [PTR_W-1:0] AF_THR = PTR_W'(AF_LEVEL);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] count_reg;
  logic             pop_valid_reg;
  logic             overflow_reg;
  logic             underflow_reg;
  logic             push_ok;
  logic             pop_ok;
  op_e              op;

  // Flags come only from registered pointers, never from this cycle's requests.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                 (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);

  // Reset masks both requests so no RAM write is issued while rst is high.
  assign push_ok = push & ~full  & ~rst;
  assign pop_ok  = pop  & ~empty & ~rst;
  assign op      = op_e'({push_ok, pop_ok});

  fifo_ptr #(.ADDR_W(ADDR_W)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .inc (push_ok),
    .ptr (wr_ptr)
  );

  fifo_ptr #(.ADDR_W(ADDR_W)) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .inc (pop_ok),
    .ptr (rd_ptr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg     <= '0;
      pop_valid_reg <= 1'b0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      case (op)
        OP_PUSH: count_reg <= count_reg + 1'b1;
        OP_POP:  count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
      pop_valid_reg <= pop_ok;
      overflow_reg  <= overflow_reg  | (push & full);
      underflow_reg <= underflow_reg | (pop & empty);
    end
  end

  assign count       = count_reg;
  assign almost_full = (count_reg >= AF_THR);
  assign pop_valid   = pop_valid_reg;
  assign overflow    = overflow_reg;
  assign underflow   = underflow_reg;

  // The RAM registers port B on the pop edge, so its output lines up with pop_valid.
  assign pop_data   = ram_dout_b;
  assign ram_we_a   = push_ok;
  assign ram_addr_a = wr_ptr[ADDR_W-1:0];
  assign ram_din_a  = push_data;
  assign ram_we_b   = 1'b0;
  assign ram_addr_b = rd_ptr[ADDR_W-1:0];
  assign ram_din_b  = '0;

endmodule
